// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: instruction word, NUM_FIELDS data
// words and a status flag, with valid bit, stall/hold, flush/bubble insertion
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 32,
  parameter int                 NUM_FIELDS = 3,
  parameter logic [DATA_W-1:0]  NOP_INSN   = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           cnt_clr,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_ins,
  input  logic [NUM_FIELDS*DATA_W-1:0]   in_fields,
  input  logic                           in_flag,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_ins,
  output logic [NUM_FIELDS*DATA_W-1:0]   out_fields,
  output logic                           out_flag,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               bubble_cnt
);

  logic                           r_valid;
  logic [DATA_W-1:0]              r_ins;
  logic [NUM_FIELDS*DATA_W-1:0]   r_fields;
  logic                           r_flag;
  logic [CNT_W-1:0]               r_stall_cnt;
  logic [CNT_W-1:0]               r_bubble_cnt;

  logic w_load_bubble;
  logic w_stall_hold;

  // Flush always wins; an un-stalled edge with nothing valid upstream is also a bubble.
  assign w_load_bubble = flush | (~stall & ~in_valid);
  assign w_stall_hold  = stall & ~flush;

  // Data path: bubble load, hold on stall, otherwise capture upstream values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_valid  <= 1'b0;
      r_ins    <= NOP_INSN;
      r_fields <= '0;
      r_flag   <= 1'b0;
    end else if (w_load_bubble) begin
      r_valid  <= 1'b0;
      r_ins    <= NOP_INSN;
      r_fields <= '0;
      r_flag   <= 1'b0;
    end else if (!stall) begin
      r_valid  <= 1'b1;
      r_ins    <= in_ins;
      r_fields <= in_fields;
      r_flag   <= in_flag;
    end
  end

  // Stall counter: counts honoured stalls, saturates, synchronous clear wins.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall_hold && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Bubble counter: counts bubble loads only (a held bubble is not a new one).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if (w_load_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_valid;
  assign out_ins    = r_ins;
  assign out_fields = r_fields;
  assign out_flag   = r_flag;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default-parameter instance (A) and a narrow
// instance (B: 16-bit, 4 fields, 4-bit counters, non-zero NOP) share control
// inputs; both are compared every cycle against a behavioural model.
module tb_pipe_stage_reg;

  localparam int           DW_B  = 16;
  localparam int           NF_B  = 4;
  localparam int           CW_B  = 4;
  localparam logic [15:0]  NOP_B = 16'h0013;
  localparam int           MAX_A = 65535;
  localparam int           MAX_B = 15;

  logic clk = 1'b0;
  logic clr;
  logic stall, flush, cnt_clr, in_valid, in_flag;

  logic [31:0] a_in_ins;
  logic [95:0] a_in_fields;
  logic        a_out_valid, a_out_flag;
  logic [31:0] a_out_ins;
  logic [95:0] a_out_fields;
  logic [15:0] a_stall_cnt, a_bubble_cnt;

  logic [15:0] b_in_ins;
  logic [63:0] b_in_fields;
  logic        b_out_valid, b_out_flag;
  logic [15:0] b_out_ins;
  logic [63:0] b_out_fields;
  logic [3:0]  b_stall_cnt, b_bubble_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ins(a_in_ins), .in_fields(a_in_fields), .in_flag(in_flag),
    .out_valid(a_out_valid), .out_ins(a_out_ins), .out_fields(a_out_fields),
    .out_flag(a_out_flag), .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW_B), .NUM_FIELDS(NF_B), .NOP_INSN(NOP_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ins(b_in_ins), .in_fields(b_in_fields), .in_flag(in_flag),
    .out_valid(b_out_valid), .out_ins(b_out_ins), .out_fields(b_out_fields),
    .out_flag(b_out_flag), .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
  );

  // Behavioural model: what each stage must hold after an edge.
  logic        m_valid, m_flag;
  logic [31:0] ma_ins;
  logic [95:0] ma_fields;
  logic [15:0] mb_ins;
  logic [63:0] mb_fields;
  int          ma_stall, ma_bubble, mb_stall, mb_bubble;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_valid <= 1'b0; m_flag <= 1'b0;
      ma_ins <= 32'h0; ma_fields <= '0; mb_ins <= NOP_B; mb_fields <= '0;
      ma_stall <= 0; ma_bubble <= 0; mb_stall <= 0; mb_bubble <= 0;
    end else begin
      if (flush || (!stall && !in_valid)) begin
        m_valid <= 1'b0; m_flag <= 1'b0;
        ma_ins <= 32'h0; ma_fields <= '0; mb_ins <= NOP_B; mb_fields <= '0;
      end else if (!stall) begin
        m_valid <= 1'b1; m_flag <= in_flag;
        ma_ins <= a_in_ins; ma_fields <= a_in_fields;
        mb_ins <= b_in_ins; mb_fields <= b_in_fields;
      end
      if (cnt_clr) begin
        ma_stall <= 0; ma_bubble <= 0; mb_stall <= 0; mb_bubble <= 0;
      end else begin
        if (stall && !flush) begin
          ma_stall <= (ma_stall < MAX_A) ? ma_stall + 1 : ma_stall;
          mb_stall <= (mb_stall < MAX_B) ? mb_stall + 1 : mb_stall;
        end
        if (flush || (!stall && !in_valid)) begin
          ma_bubble <= (ma_bubble < MAX_A) ? ma_bubble + 1 : ma_bubble;
          mb_bubble <= (mb_bubble < MAX_B) ? mb_bubble + 1 : mb_bubble;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      check("a_valid",  128'(a_out_valid),  128'(m_valid));
      check("a_ins",    128'(a_out_ins),    128'(ma_ins));
      check("a_fields", 128'(a_out_fields), 128'(ma_fields));
      check("a_flag",   128'(a_out_flag),   128'(m_flag));
      check("a_stall",  128'(a_stall_cnt),  128'(ma_stall));
      check("a_bubble", 128'(a_bubble_cnt), 128'(ma_bubble));
      check("b_valid",  128'(b_out_valid),  128'(m_valid));
      check("b_ins",    128'(b_out_ins),    128'(mb_ins));
      check("b_fields", 128'(b_out_fields), 128'(mb_fields));
      check("b_flag",   128'(b_out_flag),   128'(m_flag));
      check("b_stall",  128'(b_stall_cnt),  128'(mb_stall));
      check("b_bubble", 128'(b_bubble_cnt), 128'(mb_bubble));
    end
  end

  task automatic edge_to_negedge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_data();
    a_in_ins    = $urandom;
    a_in_fields = {$urandom, $urandom, $urandom};
    b_in_ins    = 16'($urandom);
    b_in_fields = {$urandom, $urandom};
    in_flag     = 1'($urandom);
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    randomize_data();
    repeat (2) edge_to_negedge();

    // Reset state.
    check("rst_a_valid",  128'(a_out_valid),  128'(0));
    check("rst_a_ins",    128'(a_out_ins),    128'(32'h0));
    check("rst_a_fields", 128'(a_out_fields), 128'(0));
    check("rst_a_cnts",   128'({a_stall_cnt, a_bubble_cnt}), 128'(0));
    check("rst_b_ins",    128'(b_out_ins),    128'(16'h0013));

    // Capture a real instruction.
    clr = 1'b0;
    in_valid = 1'b1; in_flag = 1'b1;
    a_in_ins = 32'h00A2_0005; a_in_fields = {32'h0, 32'h0, 32'h1234};
    b_in_ins = 16'h0005;      b_in_fields = 64'h0;
    edge_to_negedge();
    check("ld_valid",  128'(a_out_valid), 128'(1));
    check("ld_ins",    128'(a_out_ins),   128'(32'h00A2_0005));
    check("ld_field0", 128'(a_out_fields[31:0]), 128'(32'h1234));
    check("ld_flag",   128'(a_out_flag),  128'(1));

    // Three stalls while inputs change.
    stall = 1'b1; in_flag = 1'b0;
    a_in_ins = 32'hFFFF_FFFF; a_in_fields = '1; b_in_ins = 16'hFFFF; b_in_fields = '1;
    repeat (3) edge_to_negedge();
    check("st_ins",    128'(a_out_ins),   128'(32'h00A2_0005));
    check("st_field0", 128'(a_out_fields[31:0]), 128'(32'h1234));
    check("st_flag",   128'(a_out_flag),  128'(1));
    check("st_scnt",   128'(a_stall_cnt), 128'(3));
    check("st_bcnt",   128'(a_bubble_cnt), 128'(0));

    // Flush beats stall.
    flush = 1'b1; in_flag = 1'b1;
    edge_to_negedge();
    check("fl_valid", 128'(a_out_valid),  128'(0));
    check("fl_ins",   128'(a_out_ins),    128'(32'h0));
    check("fl_flag",  128'(a_out_flag),   128'(0));
    check("fl_scnt",  128'(a_stall_cnt),  128'(3));
    check("fl_bcnt",  128'(a_bubble_cnt), 128'(1));
    check("fl_b_ins", 128'(b_out_ins),    128'(16'h0013));

    // Long stall on a held bubble: narrow counter saturates.
    flush = 1'b0;
    repeat (20) edge_to_negedge();
    check("sat_b_scnt", 128'(b_stall_cnt),  128'(4'hF));
    check("sat_a_scnt", 128'(a_stall_cnt),  128'(23));
    check("sat_a_bcnt", 128'(a_bubble_cnt), 128'(1));
    check("hb_valid",   128'(b_out_valid),  128'(0));
    check("hb_ins",     128'(b_out_ins),    128'(16'h0013));

    // cnt_clr wins over the stall increment.
    cnt_clr = 1'b1;
    edge_to_negedge();
    check("cc_b_scnt", 128'(b_stall_cnt), 128'(0));
    check("cc_a_scnt", 128'(a_stall_cnt), 128'(0));

    // Bubble load from in_valid=0 with data present on the inputs.
    cnt_clr = 1'b0; stall = 1'b0; in_valid = 1'b0; in_flag = 1'b1;
    b_in_fields = 64'h4444_3333_2222_1111;
    edge_to_negedge();
    check("bu_b_fields", 128'(b_out_fields), 128'(0));
    check("bu_b_valid",  128'(b_out_valid),  128'(0));
    check("bu_b_bcnt",   128'(b_bubble_cnt), 128'(1));
    check("bu_b_flag",   128'(b_out_flag),   128'(0));

    // Randomised traffic, with an asynchronous clr pulse in the middle.
    for (int cyc = 0; cyc < 400; cyc++) begin
      randomize_data();
      stall    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cnt_clr  = ($urandom_range(0, 63) == 0);
      if (cyc == 200) begin
        #2 clr = 1'b1;
        #1;
        check("ac_a_valid", 128'(a_out_valid), 128'(0));
        check("ac_a_ins",   128'(a_out_ins),   128'(32'h0));
        check("ac_a_cnts",  128'({a_stall_cnt, a_bubble_cnt}), 128'(0));
        check("ac_b_ins",   128'(b_out_ins),   128'(16'h0013));
        check("ac_b_cnts",  128'({b_stall_cnt, b_bubble_cnt}), 128'(0));
        #1 clr = 1'b0;
      end
      edge_to_negedge();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
